// File: rtl/i2c_target.sv
// I2C target with 7-bit address: up to MAX_WR_BYTES write bytes captured into WR_DATA,
// two-byte read payload from RD_DATA, registered open-drain style SDA contribution.
module i2c_target #(
  parameter int MAX_WR_BYTES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        SDA_OUT,
  input  logic        SDA_OE,
  output logic        SDA_IN,
  input  logic [6:0]  I2C_ADDR,
  input  logic [15:0] RD_DATA,
  output logic [15:0] WR_DATA,
  output logic [1:0]  WR_COUNT,
  output logic        WR_VALID,
  output logic        BUSY,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  localparam logic [1:0] MAX_WR = 2'(MAX_WR_BYTES);

  state_t      state_q, state_d;
  logic        scl_prev_q, scl_prev_d;
  logic        sda_prev_q, sda_prev_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        ack_seen_q, ack_seen_d;
  logic        rw_q, rw_d;
  logic        wr_xfer_q, wr_xfer_d;
  logic        sda_in_q, sda_in_d;
  logic        busy_q, busy_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [1:0]  wr_count_q, wr_count_d;
  logic        wr_valid_q, wr_valid_d;

  logic       sda_bus;
  logic       start_det, stop_det, scl_rise, scl_fall, flush;
  logic [7:0] rx_next;

  // The target's own drive is part of the bus it observes (wired-AND).
  assign sda_bus   = (SDA_OE ? SDA_OUT : 1'b1) & sda_in_q;
  assign start_det = SCL & scl_prev_q & sda_prev_q & ~sda_bus;
  assign stop_det  = SCL & scl_prev_q & ~sda_prev_q & sda_bus;
  assign scl_rise  = SCL & ~scl_prev_q;
  assign scl_fall  = ~SCL & scl_prev_q;
  assign rx_next   = {rx_shift_q[6:0], sda_bus};
  assign flush     = wr_xfer_q && (byte_cnt_q != 2'd0);

  always_comb begin
    state_d    = state_q;
    scl_prev_d = SCL;
    sda_prev_d = sda_bus;
    rx_shift_d = rx_shift_q;
    rd_shift_d = rd_shift_q;
    rd_lo_d    = rd_lo_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ack_seen_d = ack_seen_q;
    rw_d       = rw_q;
    wr_xfer_d  = wr_xfer_q;
    sda_in_d   = sda_in_q;
    busy_d     = busy_q;
    wr_data_d  = wr_data_q;
    wr_count_d = 2'd0;
    wr_valid_d = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      sda_in_d  = 1'b1;
      busy_d    = 1'b0;
      wr_xfer_d = 1'b0;
      if (flush) begin
        wr_valid_d = 1'b1;
        wr_count_d = byte_cnt_q;
      end
    end else if (start_det) begin
      if (state_q != IDLE && flush) begin
        wr_valid_d = 1'b1;
        wr_count_d = byte_cnt_q;
      end
      state_d    = ADDR;
      busy_d     = 1'b1;
      sda_in_d   = 1'b1;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = 2'd0;
      ack_seen_d = 1'b0;
      wr_xfer_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (rx_next[7:1] == I2C_ADDR) begin
                rw_d       = rx_next[0];
                wr_xfer_d  = ~rx_next[0];
                rd_shift_d = RD_DATA[15:8];
                rd_lo_d    = RD_DATA[7:0];
                ack_seen_d = 1'b0;
                state_d    = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_in_d = 1'b0;
            end else begin
              ack_seen_d = 1'b0;
              if (rw_q) begin
                // First read bit goes out on the same fall that ends the ACK.
                sda_in_d   = rd_shift_q[7];
                rd_shift_d = {rd_shift_q[6:0], 1'b1};
                bit_cnt_d  = 4'd1;
                state_d    = RD_BYTE;
              end else begin
                sda_in_d  = 1'b1;
                bit_cnt_d = 4'd0;
                state_d   = WR_BYTE;
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_cnt_q < MAX_WR) begin
                if (byte_cnt_q == 2'd0) wr_data_d[15:8] = rx_next;
                else                    wr_data_d[7:0]  = rx_next;
                byte_cnt_d = byte_cnt_q + 2'd1;
                ack_seen_d = 1'b0;
                state_d    = WR_ACK;
              end else begin
                // Byte beyond capacity: left NACKed and not stored.
                state_d = WAIT_STOP;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_in_d = 1'b0;
            end else begin
              ack_seen_d = 1'b0;
              sda_in_d   = 1'b1;
              bit_cnt_d  = 4'd0;
              state_d    = WR_BYTE;
            end
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_in_d   = 1'b1;
              ack_seen_d = 1'b0;
              state_d    = RD_ACK;
            end else begin
              sda_in_d   = rd_shift_q[7];
              rd_shift_d = {rd_shift_q[6:0], 1'b1};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_bus) begin
              ack_seen_d = 1'b1;
              rd_shift_d = (byte_cnt_q == 2'd0) ? rd_lo_q : 8'hFF;
              byte_cnt_d = 2'd1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && ack_seen_q) begin
            ack_seen_d = 1'b0;
            sda_in_d   = rd_shift_q[7];
            rd_shift_d = {rd_shift_q[6:0], 1'b1};
            bit_cnt_d  = 4'd1;
            state_d    = RD_BYTE;
          end
        end
        WAIT_STOP: sda_in_d = 1'b1;
        default:   state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      rx_shift_q <= 8'h00;
      rd_shift_q <= 8'h00;
      rd_lo_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 2'd0;
      ack_seen_q <= 1'b0;
      rw_q       <= 1'b0;
      wr_xfer_q  <= 1'b0;
      sda_in_q   <= 1'b1;
      busy_q     <= 1'b0;
      wr_data_q  <= 16'h0000;
      wr_count_q <= 2'd0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      rx_shift_q <= rx_shift_d;
      rd_shift_q <= rd_shift_d;
      rd_lo_q    <= rd_lo_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ack_seen_q <= ack_seen_d;
      rw_q       <= rw_d;
      wr_xfer_q  <= wr_xfer_d;
      sda_in_q   <= sda_in_d;
      busy_q     <= busy_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  assign SDA_IN    = sda_in_q;
  assign BUSY      = busy_q;
  assign WR_DATA   = wr_data_q;
  assign WR_COUNT  = wr_count_q;
  assign WR_VALID  = wr_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master drives the bus; write-transfer
// results are checked through an expected/observed WR_VALID scoreboard.
module tb_i2c_target;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SCL = 1'b1;
  logic        SDA_OUT = 1'b1;
  logic        SDA_OE = 1'b0;
  logic        SDA_IN;
  logic [6:0]  I2C_ADDR = 7'h2A;
  logic [15:0] RD_DATA = 16'h0000;
  logic [15:0] WR_DATA;
  logic [1:0]  WR_COUNT;
  logic        WR_VALID;
  logic        BUSY;
  logic [2:0]  state_dbg;

  logic        sda_bus;
  int          vectors = 0;
  int          miscompares = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  localparam int Q = 4;

  i2c_target #(.MAX_WR_BYTES(2)) dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
    .SDA_IN(SDA_IN), .I2C_ADDR(I2C_ADDR), .RD_DATA(RD_DATA), .WR_DATA(WR_DATA),
    .WR_COUNT(WR_COUNT), .WR_VALID(WR_VALID), .BUSY(BUSY), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  assign sda_bus = (SDA_OE ? SDA_OUT : 1'b1) & SDA_IN;

  // Every cycle WR_VALID is high is recorded, so a stretched pulse shows up as an extra entry.
  always @(negedge CLK) begin
    if (WR_VALID) obs_q.push_back({WR_COUNT, WR_DATA});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic i2c_start();
    SDA_OE = 1'b1; SDA_OUT = 1'b1;
    wait_clk(Q);
    SCL = 1'b1;
    wait_clk(2 * Q);
    SDA_OUT = 1'b0;
    wait_clk(2 * Q);
    SCL = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    SDA_OE = 1'b1; SDA_OUT = 1'b0;
    wait_clk(Q);
    SCL = 1'b1;
    wait_clk(2 * Q);
    SDA_OUT = 1'b1;
    wait_clk(2 * Q);
    SDA_OE = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    SDA_OE = 1'b1; SDA_OUT = b;
    wait_clk(Q);
    SCL = 1'b1;
    wait_clk(2 * Q);
    SCL = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    SDA_OE = 1'b0;
    wait_clk(Q);
    SCL = 1'b1;
    wait_clk(Q);
    b = sda_bus;
    wait_clk(Q);
    SCL = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_ack);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    wait_clk(3);
    vectors++; if (SDA_IN !== 1'b1) begin miscompares++; $display("FAIL reset_sda_in: got %b expected 1", SDA_IN); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    vectors++; if (WR_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid: got %b expected 0", WR_VALID); end
    vectors++; if (WR_COUNT !== 2'd0) begin miscompares++; $display("FAIL reset_wr_count: got %0d expected 0", WR_COUNT); end
    vectors++; if (WR_DATA !== 16'h0000) begin miscompares++; $display("FAIL reset_wr_data: got %h expected 0000", WR_DATA); end
    vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    RESET = 1'b1;
    wait_clk(3);
  endtask

  task automatic test_write();
    logic        ack;
    logic [7:0]  bytes [3];
    logic [17:0] got, exp;
    bytes[0] = 8'h54; bytes[1] = 8'hBE; bytes[2] = 8'hEF;
    i2c_start();
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL write_busy_start: got %b expected 1", BUSY); end
    for (int i = 0; i < 3; i++) begin
      write_byte(bytes[i], ack);
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL write_ack byte %0d: got %b expected 0", i, ack); end
    end
    exp_q.push_back({2'd2, 16'hBEEF});
    i2c_stop();
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL write_busy_stop: got %b expected 0", BUSY); end
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 18'h3FFFF;
    exp = exp_q.pop_front();
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL write_wr_valid: got %h expected %h", got, exp); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL write_extra_pulse: got %0d expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] d;
    RD_DATA = 16'h1234;
    i2c_start();
    write_byte(8'h55, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL read_addr_ack: got %b expected 0", ack); end
    read_byte(d, 1'b0);
    vectors++; if (d !== 8'h12) begin miscompares++; $display("FAIL read_byte0: got %h expected 12", d); end
    read_byte(d, 1'b1);
    vectors++; if (d !== 8'h34) begin miscompares++; $display("FAIL read_byte1: got %h expected 34", d); end
    i2c_stop();
    vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL read_idle: got %0d expected 0", state_dbg); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL read_busy: got %b expected 0", BUSY); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL read_wr_valid: got %0d expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_read_past_end();
    logic       ack;
    logic [7:0] d;
    logic [7:0] exp_b [3];
    RD_DATA = 16'h9A6B;
    exp_b[0] = 8'h9A; exp_b[1] = 8'h6B; exp_b[2] = 8'hFF;
    i2c_start();
    write_byte(8'h55, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rdpe_addr_ack: got %b expected 0", ack); end
    for (int i = 0; i < 3; i++) begin
      read_byte(d, (i == 2) ? 1'b1 : 1'b0);
      vectors++; if (d !== exp_b[i]) begin miscompares++; $display("FAIL rdpe_byte%0d: got %h expected %h", i, d, exp_b[i]); end
    end
    i2c_stop();
  endtask

  task automatic test_mismatch();
    logic ack;
    i2c_start();
    write_byte(8'h56, ack);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL mismatch_addr_ack: got %b expected 1", ack); end
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL mismatch_busy: got %b expected 1", BUSY); end
    write_byte(8'h00, ack);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL mismatch_data_ack: got %b expected 1", ack); end
    i2c_stop();
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL mismatch_busy_stop: got %b expected 0", BUSY); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL mismatch_wr_valid: got %0d expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_overflow();
    logic        ack;
    logic [7:0]  bytes [4];
    logic        exp_ack [4];
    logic [17:0] got, exp;
    bytes[0] = 8'h54; bytes[1] = 8'h01; bytes[2] = 8'h02; bytes[3] = 8'h03;
    exp_ack[0] = 1'b0; exp_ack[1] = 1'b0; exp_ack[2] = 1'b0; exp_ack[3] = 1'b1;
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      vectors++; if (ack !== exp_ack[i]) begin miscompares++; $display("FAIL overflow_ack byte %0d: got %b expected %b", i, ack, exp_ack[i]); end
    end
    exp_q.push_back({2'd2, 16'h0102});
    i2c_stop();
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 18'h3FFFF;
    exp = exp_q.pop_front();
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL overflow_wr_valid: got %h expected %h", got, exp); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL overflow_extra_pulse: got %0d expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic        ack;
    logic [7:0]  d;
    logic [17:0] got, exp;
    RD_DATA = 16'hC35A;
    i2c_start();
    write_byte(8'h54, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL b2b_addr_ack: got %b expected 0", ack); end
    write_byte(8'hA5, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL b2b_data_ack: got %b expected 0", ack); end
    // Low byte still holds 0x02 from the previous two-byte write.
    exp_q.push_back({2'd1, 16'hA502});
    i2c_start();
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_rstart: got %b expected 1", BUSY); end
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 18'h3FFFF;
    exp = exp_q.pop_front();
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL b2b_wr_valid: got %h expected %h", got, exp); end
    write_byte(8'h55, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL b2b_read_ack: got %b expected 0", ack); end
    read_byte(d, 1'b1);
    vectors++; if (d !== 8'hC3) begin miscompares++; $display("FAIL b2b_read_byte: got %h expected c3", d); end
    i2c_stop();
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra_pulse: got %0d expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_midread();
    logic        ack, b;
    logic [17:0] got, exp;
    RD_DATA = 16'h0000;
    i2c_start();
    write_byte(8'h55, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_addr_ack: got %b expected 0", ack); end
    for (int i = 0; i < 3; i++) read_bit(b);
    vectors++; if (SDA_IN !== 1'b0) begin miscompares++; $display("FAIL rst_driving_low: got %b expected 0", SDA_IN); end
    #2 RESET = 1'b0;
    #1;
    vectors++; if (SDA_IN !== 1'b1) begin miscompares++; $display("FAIL rst_async_sda: got %b expected 1", SDA_IN); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy: got %b expected 0", BUSY); end
    wait_clk(2);
    RESET = 1'b1;
    SCL = 1'b1;
    wait_clk(2 * Q);
    vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL rst_idle: got %0d expected 0", state_dbg); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rst_wr_valid: got %0d expected 0", obs_q.size()); obs_q.delete(); end
    i2c_start();
    write_byte(8'h54, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_next_addr_ack: got %b expected 0", ack); end
    write_byte(8'h77, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_next_data_ack: got %b expected 0", ack); end
    exp_q.push_back({2'd1, 16'h7700});
    i2c_stop();
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 18'h3FFFF;
    exp = exp_q.pop_front();
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL rst_next_wr_valid: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_past_end();
    test_mismatch();
    test_overflow();
    test_back_to_back();
    test_reset_midread();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL pending_expected: got %0d expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter MAX_WR_BYTES, default 2, the number of write data bytes ACKed per transfer (legal values 1 or 2).
REQ-002 SHALL have port CLK, input, 1, system clock; all logic is clocked on the rising edge.
REQ-003 SHALL have port RESET, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port SCL, input, 1, bus clock from the master.
REQ-005 SHALL have port SDA_OUT, input, 1, master SDA drive value.
REQ-006 SHALL have port SDA_OE, input, 1, master SDA drive enable.
REQ-007 SHALL have port SDA_IN, output, 1, target contribution to SDA (0 = pull low, 1 = released); it is a registered output.
REQ-008 SHALL have port I2C_ADDR, input, 7, own target address.
REQ-009 SHALL have port RD_DATA, input, 16, read payload: [15:8] is sent first, then [7:0].
REQ-010 SHALL have port WR_DATA, output, 16, captured write bytes: first byte in [15:8], second in [7:0].
REQ-011 SHALL have port WR_COUNT, output, 2, number of write bytes captured, valid while WR_VALID is high.
REQ-012 SHALL have port WR_VALID, output, 1, one-CLK pulse marking the end of a write transfer.
REQ-013 SHALL have port BUSY, output, 1, high from START until STOP.

Function
REQ-014 SHALL form bus SDA = (SDA_OE ? SDA_OUT : 1) AND SDA_IN, and register SCL and bus SDA once per CLK as previous-sample copies.
REQ-015 SHALL detect START when SCL is high in both the current and previous sample and SDA goes 1->0; STOP is the same with SDA going 0->1.
REQ-016 SHALL treat SCL rise (prev 0, current 1) as the data-sample event and SCL fall (prev 1, current 0) as the drive-update event.
REQ-017 SHALL give START/STOP detection priority over any bit event in the same CLK.
REQ-018 SHALL use states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-019 IDLE: on START, go to ADDR, set BUSY = 1, and clear the bit counter and byte counter.
REQ-020 ADDR: shift in 8 bits MSB-first on SCL rises; after the 8th rise, compare bits [7:1] with I2C_ADDR.
REQ-021 ADDR on match: latch RD_DATA into the read shift register and go to ADDR_ACK.
REQ-022 ADDR on mismatch: go to WAIT_STOP with SDA_IN held at 1.
REQ-023 ADDR_ACK: drive SDA_IN = 0 one CLK after the next SCL fall, and hold it through the 9th SCL high.
REQ-024 ADDR_ACK exit: on the following SCL fall, go to RD_BYTE if R/W = 1, otherwise go to WR_BYTE with SDA_IN = 1.
REQ-025 WR_BYTE: shift in 8 bits; after the 8th rise, store the byte into WR_DATA[15:8] or [7:0] according to the byte counter, increment the counter, and go to WR_ACK.
REQ-026 WR_ACK: if byte counter <= MAX_WR_BYTES, drive ACK (0) for the 9th clock and return to WR_BYTE on the next fall.
REQ-027 WR_ACK: otherwise leave SDA_IN = 1 (NACK), discard the byte, and go to WAIT_STOP.
REQ-028 RD_BYTE: drive SDA_IN with the shift-register MSB one CLK after each SCL fall, with the first bit driven at the fall that ends ADDR_ACK.
REQ-029 RD_BYTE: release SDA_IN = 1 at the fall after the 8th bit and go to RD_ACK.
REQ-030 Read byte source: byte 1 = RD_DATA[15:8], byte 2 = RD_DATA[7:0], byte 3 onward = 8'hFF.
REQ-031 RD_ACK: sample SDA at the 9th rise; 0 (ACK) returns to RD_BYTE with the next byte, 1 (NACK) goes to WAIT_STOP.
REQ-032 WAIT_STOP: hold SDA_IN = 1 and ignore bits.
REQ-033 STOP in any state: go to IDLE, set SDA_IN = 1 and BUSY = 0.
REQ-034 STOP on a write transfer: if it captured >= 1 byte, pulse WR_VALID for 1 CLK with WR_COUNT equal to bytes captured; WR_DATA holds until the next captured byte.
REQ-035 Repeated START in any non-IDLE state: perform the same WR_VALID flush as STOP, then go to ADDR with counters cleared, SDA_IN = 1, and BUSY held at 1.
REQ-036 Latency: SDA_IN SHALL change exactly 1 CLK after the CLK in which the SCL fall is detected.
REQ-037 SHALL never change SDA_IN while the registered SCL is high, except for releasing on reset or STOP.

Reset
REQ-038 RESET low SHALL asynchronously force IDLE and clear all counters and shift registers.
REQ-039 RESET low SHALL set SDA_IN = 1, BUSY = 0, WR_VALID = 0, WR_COUNT = 0, WR_DATA = 16'h0000, with previous-sample SCL/SDA = 1.
REQ-040 Reset asserted mid-transfer SHALL release SDA within the same cycle, emit no WR_VALID, and require a fresh START after deassertion.

Verification
REQ-041 I2C_ADDR=7'h2A; START, 0x54, 0xBE, 0xEF, STOP -> ACK on all three 9th clocks; WR_VALID pulse with WR_DATA=16'hBEEF, WR_COUNT=2.
REQ-042 I2C_ADDR=7'h2A, RD_DATA=16'h1234; START, 0x55, master ACK then NACK -> bits 0x12 then 0x34 on SDA_IN, then IDLE after STOP.
REQ-043 I2C_ADDR=7'h2A; START, 0x56 -> SDA_IN stays 1 through STOP, BUSY 1->0, no WR_VALID.
REQ-044 MAX_WR_BYTES=2; write 0x54, 0x01, 0x02, 0x03 -> NACK on the third data byte, WR_DATA=16'h0102, WR_COUNT=2 at STOP.
REQ-045 Write 0x54, 0xA5, repeated START, 0x55 read -> WR_VALID with WR_COUNT=1, WR_DATA[15:8]=8'hA5, then read ACKed.
REQ-046 RESET low during RD_BYTE while driving 0 -> SDA_IN=1 asynchronously and BUSY=0; the next transfer works normally.
